if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, issues instruction-memory requests, and drives the IF/ID pipeline register consumed by decode. It obeys the stall controls produced by the load-use hazard detection unit (`pc_write_enable`, `if_id_write_enable`) and the redirect/flush from branch/jump resolution. It holds a returned instruction across stalls and drains in-flight requests on redirect.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `ADDR_W`, default 32: PC and instruction-memory address width.
- `DATA_W`, default 32: instruction width.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `pc_write_enable`  in  1: from the hazard unit; 0 freezes the PC.
- `if_id_write_enable`  in  1: from the hazard unit; 0 freezes the IF/ID register.
- `redirect_valid`  in  1: branch taken or jump resolved; flush and redirect.
- `redirect_pc`  in  ADDR_W: redirect target. Bits [1:0] are forced to 0.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  ADDR_W: fetch address.
- `imem_ready`  in  1: the request completes in the cycle where `imem_req && imem_ready`.
- `imem_rdata`  in  DATA_W: instruction. Valid only in the completion cycle.
- `if_id_instr`  out  DATA_W: IF/ID instruction.
- `if_id_pc_plus4`  out  ADDR_W: IF/ID PC+4.
- `if_id_valid`  out  1: IF/ID holds a real instruction (0 = bubble).

## Operation
- Reset values:
  - pc = RESET_PC.
  - state = IDLE.
  - `imem_req` = 0.
  - `if_id_instr` = 0 (NOP).
  - `if_id_pc_plus4` = 0.
  - `if_id_valid` = 0.
  - hold buffer cleared.
- States:
  - IDLE: no request; next state FETCH.
  - FETCH: `imem_req` = 1, `imem_addr` = pc.
    - Completion with `if_id_write_enable`=1: load IF/ID with {rdata, pc+4, valid=1}; pc <= pc+4 if `pc_write_enable`; stay in FETCH.
    - Completion with `if_id_write_enable`=0: capture rdata and pc+4 into the hold buffer; go to HOLD.
    - No completion with `if_id_write_enable`=1: IF/ID valid <= 0 (bubble); PC unchanged.
    - No completion with `if_id_write_enable`=0: IF/ID holds.
  - HOLD: `imem_req` = 0; IF/ID holds. When `if_id_write_enable`=1: load IF/ID from the hold buffer, pc <= pc+4, go to FETCH.
  - DRAIN: `imem_req` = 1, `imem_addr` = drain_addr (stable). On `imem_ready`: discard rdata, go to FETCH.
- Redirect has the highest priority and overrides stall inputs:
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - IF/ID <= {NOP, 0, valid=0}.
  - Hold buffer invalidated.
  - From FETCH with `imem_ready`=0: drain_addr <= current pc, go to DRAIN (the address must not change under a pending request).
  - From FETCH with `imem_ready`=1, or from HOLD/IDLE: go to FETCH (the completing response is discarded).
  - In DRAIN: pc updated, stay in DRAIN.
- Arithmetic: pc+4 is modulo 2^ADDR_W; 32'hFFFF_FFFC + 4 wraps to 0.
- `imem_req` and `imem_addr` are combinational from state/pc. IF/ID outputs are registered.
- Reset asserted mid-request or in DRAIN: the request is abandoned, outputs return to reset values at that edge, and no response is consumed.

## Timing
- `rst_n` deasserted at edge E0: IDLE for cycle 1, `imem_req` first high in cycle 2. With `imem_ready` tied high, `if_id_valid` = 1 after edge E2 with pc = RESET_PC.
- Steady state with no stalls: one instruction per cycle; IF/ID latency is 1 edge from completion.
- Stall (both enables 0) for N cycles: IF/ID and PC frozen N cycles. The held instruction enters IF/ID on the first edge with the enables at 1.
- Redirect sampled at edge E: IF/ID is a bubble after E. The target is requested in cycle E+1, or after the drain completes.

## Configuration
- `IF_PERF_CNT_EN` defined adds two ports and counters:
  - `perf_stall_cnt` (out, 32): counts cycles with `if_id_write_enable`=0.
  - `perf_flush_cnt` (out, 32): counts cycles with `redirect_valid`=1.
  - Both are 0 at reset and wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `if_pkg`:
  - State enum {IDLE, FETCH, HOLD, DRAIN}.
  - `NOP_INSTR` = 32'h0000_0000.
  - `PC_INC` = 4.
- Sub-module `if_id_reg`: the IF/ID register, with inputs enable, flush (priority over enable), instr, pc_plus4, valid.

## Test plan
- Reset with RESET_PC=32'h0040_0000, `imem_ready`=1, rdata=32'h2008_0005: after E2, `if_id_instr`=32'h2008_0005, `if_id_pc_plus4`=32'h0040_0004, `if_id_valid`=1.
- Load-use stall: enables at 0 for 1 cycle during a completion → IF/ID holds, state is HOLD, `imem_req`=0. Next cycle the buffered instruction loads; no instruction is lost or duplicated.
- Redirect to 32'h0000_1003 while `imem_ready`=0:
  - Next cycle state is DRAIN and `imem_addr` equals the old pc.
  - After ready, `imem_addr`=32'h0000_1000.
  - IF/ID valid stays 0 until the new fetch completes.
- Redirect and stall in the same cycle → the flush wins: `if_id_valid`=0 and pc = target.
- PC at 32'hFFFF_FFFC completes a fetch → `if_id_pc_plus4`=0 and the next `imem_addr`=0.
- `rst_n` low during DRAIN → the next cycle is IDLE, `imem_req`=0, and pc=RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package if_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } if_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam int          PC_INC    = 4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; flush beats enable and loads a NOP bubble.
import if_pkg::*;

module if_id_reg #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              flush,
   input  logic [DATA_W-1:0] instr,
   input  logic [ADDR_W-1:0] pc_plus4,
   input  logic              valid,
   output logic [DATA_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0] if_id_pc_plus4,
   output logic              if_id_valid
);

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         if_id_instr    <= DATA_W'(NOP_INSTR);
         if_id_pc_plus4 <= '0;
         if_id_valid    <= 1'b0;
      end else if (enable) begin
         if_id_instr    <= instr;
         if_id_pc_plus4 <= pc_plus4;
         if_id_valid    <= valid;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem requests, stall hold buffer, redirect drain.
// Define IF_PERF_CNT_EN to add the stall/flush performance counters.
import if_pkg::*;

module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32,
   parameter int          DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pc_write_enable,
   input  logic              if_id_write_enable,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0] if_id_pc_plus4,
   output logic              if_id_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_flush_cnt
`endif
);

   if_state_t         state, state_n;
   logic [ADDR_W-1:0] pc, pc_n, pc_plus4;
   logic [ADDR_W-1:0] drain_addr, drain_addr_n;
   logic [DATA_W-1:0] hold_instr, hold_instr_n;
   logic [ADDR_W-1:0] hold_pc4, hold_pc4_n;
   logic              hold_valid, hold_valid_n;

   logic              ld_en, ld_flush, ld_valid;
   logic [DATA_W-1:0] ld_instr;
   logic [ADDR_W-1:0] ld_pc4;

   assign pc_plus4  = pc + ADDR_W'(PC_INC);
   assign imem_req  = (state == FETCH) || (state == DRAIN);
   assign imem_addr = (state == DRAIN) ? drain_addr : pc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= ADDR_W'(RESET_PC);
         drain_addr <= '0;
         hold_instr <= '0;
         hold_pc4   <= '0;
         hold_valid <= 1'b0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         drain_addr <= drain_addr_n;
         hold_instr <= hold_instr_n;
         hold_pc4   <= hold_pc4_n;
         hold_valid <= hold_valid_n;
      end
   end

   always_comb begin
      state_n      = state;
      pc_n         = pc;
      drain_addr_n = drain_addr;
      hold_instr_n = hold_instr;
      hold_pc4_n   = hold_pc4;
      hold_valid_n = hold_valid;
      ld_en        = 1'b0;
      ld_flush     = 1'b0;
      ld_instr     = DATA_W'(NOP_INSTR);
      ld_pc4       = '0;
      ld_valid     = 1'b0;

      if (redirect_valid) begin
         pc_n         = {redirect_pc[ADDR_W-1:2], 2'b00};
         ld_flush     = 1'b1;
         hold_valid_n = 1'b0;
         case (state)
            // a pending request keeps its address until the memory accepts it
            FETCH:   if (!imem_ready) begin
                        drain_addr_n = pc;
                        state_n      = DRAIN;
                     end
            DRAIN:   state_n = DRAIN;
            default: state_n = FETCH;
         endcase
      end else begin
         case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
               if (imem_ready) begin
                  if (if_id_write_enable) begin
                     ld_en    = 1'b1;
                     ld_instr = imem_rdata;
                     ld_pc4   = pc_plus4;
                     ld_valid = 1'b1;
                     if (pc_write_enable) pc_n = pc_plus4;
                  end else begin
                     hold_instr_n = imem_rdata;
                     hold_pc4_n   = pc_plus4;
                     hold_valid_n = 1'b1;
                     state_n      = HOLD;
                  end
               end else if (if_id_write_enable) begin
                  ld_en = 1'b1;
               end
            end
            HOLD: begin
               if (if_id_write_enable) begin
                  ld_en        = 1'b1;
                  ld_instr     = hold_instr;
                  ld_pc4       = hold_pc4;
                  ld_valid     = hold_valid;
                  hold_valid_n = 1'b0;
                  pc_n         = pc_plus4;
                  state_n      = FETCH;
               end
            end
            DRAIN: begin
               ld_en = if_id_write_enable;
               if (imem_ready) state_n = FETCH;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   if_id_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if_id_reg (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (ld_en),
      .flush          (ld_flush),
      .instr          (ld_instr),
      .pc_plus4       (ld_pc4),
      .valid          (ld_valid),
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_valid    (if_id_valid)
   );

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (!if_id_write_enable) perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (redirect_valid)      perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed plan items then randomized traffic vs a behavioural model.
module tb_if_stage;

   localparam logic [31:0] RPC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pwe = 1'b1, iwe = 1'b1, rv = 1'b0, rdy = 1'b0;
   logic [31:0] rpc = '0, rdata = '0;
   logic        imem_req, if_id_valid;
   logic [31:0] imem_addr, if_id_instr, if_id_pc_plus4;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

   int tests = 0;
   int fails = 0;

   // behavioural model: where the fetcher is, plus what the IF/ID register should hold
   logic [31:0] m_pc, m_daddr, m_binstr, m_bpc4, m_instr, m_pc4;
   logic        m_valid;
   bit          m_idle, m_hold, m_drain;
   logic [31:0] m_stall, m_flush;

   if_stage #(.RESET_PC(RPC), .ADDR_W(32), .DATA_W(32)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .pc_write_enable    (pwe),
      .if_id_write_enable (iwe),
      .redirect_valid     (rv),
      .redirect_pc        (rpc),
      .imem_req           (imem_req),
      .imem_addr          (imem_addr),
      .imem_ready         (rdy),
      .imem_rdata         (rdata),
      .if_id_instr        (if_id_instr),
      .if_id_pc_plus4     (if_id_pc_plus4),
      .if_id_valid        (if_id_valid)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_stall_cnt     (perf_stall_cnt),
      .perf_flush_cnt     (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic [31:0] p4;
      p4 = m_pc + 32'd4;
      if (!rst_n) begin
         m_pc = RPC; m_idle = 1; m_hold = 0; m_drain = 0;
         m_instr = 0; m_pc4 = 0; m_valid = 0; m_stall = 0; m_flush = 0;
         return;
      end
      if (!iwe) m_stall++;
      if (rv)   m_flush++;
      if (rv) begin
         if (!m_idle && !m_hold && !m_drain && !rdy) begin
            m_daddr = m_pc;
            m_drain = 1;
         end
         m_idle = 0; m_hold = 0;
         m_pc = {rpc[31:2], 2'b00};
         m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (m_idle) begin
         m_idle = 0;
      end else if (m_hold) begin
         if (iwe) begin
            m_instr = m_binstr; m_pc4 = m_bpc4; m_valid = 1;
            m_pc = p4; m_hold = 0;
         end
      end else if (m_drain) begin
         if (iwe) begin m_instr = 0; m_pc4 = 0; m_valid = 0; end
         if (rdy) m_drain = 0;
      end else if (rdy) begin
         if (iwe) begin
            m_instr = rdata; m_pc4 = p4; m_valid = 1;
            if (pwe) m_pc = p4;
         end else begin
            m_binstr = rdata; m_bpc4 = p4; m_hold = 1;
         end
      end else if (iwe) begin
         m_instr = 0; m_pc4 = 0; m_valid = 0;
      end
   endtask

   task automatic check_all(input string tag);
      logic exp_req;
      exp_req = !m_idle && !m_hold;
      chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, exp_req});
      if (exp_req) chk({tag, ".addr"}, imem_addr, m_drain ? m_daddr : m_pc);
      chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
      chk({tag, ".instr"}, if_id_instr, m_instr);
      chk({tag, ".pc4"}, if_id_pc_plus4, m_pc4);
`ifdef IF_PERF_CNT_EN
      chk({tag, ".stall_cnt"}, perf_stall_cnt, m_stall);
      chk({tag, ".flush_cnt"}, perf_flush_cnt, m_flush);
`endif
   endtask

   // inputs are driven at the negedge; model and DUT both advance on the next posedge
   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_all(tag);
   endtask

   initial begin
      logic [31:0] old_pc;
      @(negedge clk);

      // reset and first fetch
      rst_n = 0; rdy = 1; rdata = 32'h2008_0005;
      step("rst0"); step("rst1");
      chk("rst.req", {31'd0, imem_req}, 32'd0);
      chk("rst.valid", {31'd0, if_id_valid}, 32'd0);
      rst_n = 1;
      step("e1");
      chk("e1.req", {31'd0, imem_req}, 32'd1);
      chk("e1.addr", imem_addr, 32'h0040_0000);
      step("e2");
      chk("e2.instr", if_id_instr, 32'h2008_0005);
      chk("e2.pc4", if_id_pc_plus4, 32'h0040_0004);
      chk("e2.valid", {31'd0, if_id_valid}, 32'd1);

      // load-use stall for one cycle during a completion
      rdata = 32'h1111_0001; step("run1");
      rdata = 32'h2222_0002; pwe = 0; iwe = 0; step("stall");
      chk("stall.req", {31'd0, imem_req}, 32'd0);
      chk("stall.instr", if_id_instr, 32'h1111_0001);
      rdata = 32'h3333_0003; pwe = 1; iwe = 1; step("unstall");
      chk("unstall.instr", if_id_instr, 32'h2222_0002);
      chk("unstall.pc4", if_id_pc_plus4, 32'h0040_000C);
      step("resume");
      chk("resume.instr", if_id_instr, 32'h3333_0003);
      chk("resume.pc4", if_id_pc_plus4, 32'h0040_0010);

      // redirect while the request is pending -> drain
      old_pc = imem_addr;
      rv = 1; rpc = 32'h0000_1003; rdy = 0; step("redir");
      chk("drain.addr", imem_addr, old_pc);
      chk("drain.valid", {31'd0, if_id_valid}, 32'd0);
      rv = 0; step("drain_wait");
      rdy = 1; step("drain_done");
      chk("tgt.addr", imem_addr, 32'h0000_1000);
      chk("tgt.valid", {31'd0, if_id_valid}, 32'd0);
      rdata = 32'hABCD_0000; step("tgt_fetch");
      chk("tgt.pc4", if_id_pc_plus4, 32'h0000_1004);

      // redirect together with a stall: flush wins
      rv = 1; rpc = 32'h0000_2000; pwe = 0; iwe = 0; step("redir_stall");
      chk("rs.valid", {31'd0, if_id_valid}, 32'd0);
      chk("rs.addr", imem_addr, 32'h0000_2000);
      rv = 0; pwe = 1; iwe = 1;

      // PC wraps at the top of the address space
      rv = 1; rpc = 32'hFFFF_FFFC; step("to_top");
      rv = 0; rdata = 32'h0BAD_F00D; step("wrap");
      chk("wrap.pc4", if_id_pc_plus4, 32'h0000_0000);
      chk("wrap.addr", imem_addr, 32'h0000_0000);

      // reset while draining
      rv = 1; rpc = 32'h0000_3000; rdy = 0; step("redir2");
      rv = 0; rst_n = 0; step("rst_drain");
      chk("rd.req", {31'd0, imem_req}, 32'd0);
      chk("rd.pc", imem_addr, RPC);
      rst_n = 1; rdy = 1; step("rd_idle");

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst_n = ($urandom_range(0, 59) != 0);
         rv    = ($urandom_range(0, 7) == 0);
         rpc   = $urandom;
         rdy   = ($urandom_range(0, 2) != 0);
         rdata = $urandom;
         iwe   = ($urandom_range(0, 3) != 0);
         pwe   = ($urandom_range(0, 7) == 0) ? ~iwe : iwe;
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
